// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD command scheduler.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    StArb,
    StIssue,
    StWaitHi,
    StWaitLo,
    StDrain,
    StFin
  } sched_state_e;

  localparam logic [3:0] CmdWrite  = 4'd0;
  localparam logic [3:0] CmdUp     = 4'd1;
  localparam logic [3:0] CmdDown   = 4'd2;
  localparam logic [3:0] CmdLeft   = 4'd3;
  localparam logic [3:0] CmdRight  = 4'd4;
  localparam logic [3:0] CmdMax    = 4'd5;
  localparam logic [3:0] CmdMin    = 4'd6;
  localparam logic [3:0] CmdAvg    = 4'd7;
  localparam logic [3:0] CmdRotCcw = 4'd8;
  localparam logic [3:0] CmdRotCw  = 4'd9;
  localparam logic [3:0] CmdMirX   = 4'd10;
  localparam logic [3:0] CmdMirY   = 4'd11;

  localparam logic [3:0] NopCmdDefault = 4'hF;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Per-host 4-bit command FIFO with a synchronous flush; head is the oldest entry.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] wdata,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic [3:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-host round-robin command scheduler for the LCD controller command port.
// Optional watchdog on WAIT_HI/DRAIN is built when LCD_SCHED_WDOG_EN is defined.
module lcd_cmd_sched
  import lcd_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  NOP_CMD    = NopCmdDefault,
  parameter int unsigned WDOG_CYC   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] h0_cmd,
  input  logic       h0_valid,
  output logic       h0_ready,
  input  logic [3:0] h1_cmd,
  input  logic       h1_valid,
  output logic       h1_ready,
  output logic [3:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  input  logic       lcd_busy,
  input  logic       lcd_done,
  output logic       grant_id,
  output logic       sched_idle,
  output logic       finished,
  output logic       wdog_err
);

  sched_state_e state_q;
  logic         prefer_q;
  logic         full0, full1, empty0, empty1;
  logic [3:0]   head0, head1;
  logic         elig0, elig1, both_zero, sel, issue_go;
  logic         pop0, pop1, drain_lock, wdog_hit;

  assign drain_lock = (state_q == StDrain) || (state_q == StFin);
  assign h0_ready   = !full0 && !drain_lock;
  assign h1_ready   = !full1 && !drain_lock;
  assign sched_idle = empty0 && empty1 && (state_q == StArb);

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (h0_valid && h0_ready),
    .wdata (h0_cmd),
    .pop   (pop0),
    .flush (drain_lock),
    .full  (full0),
    .empty (empty0),
    .head  (head0)
  );

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (h1_valid && h1_ready),
    .wdata (h1_cmd),
    .pop   (pop1),
    .flush (drain_lock),
    .full  (full1),
    .empty (empty1),
    .head  (head1)
  );

  // A WRITE head waits until the other host has nothing queued.
  assign both_zero = !empty0 && !empty1 && (head0 == CmdWrite) && (head1 == CmdWrite);
  assign elig0     = (!empty0 && ((head0 != CmdWrite) || empty1)) || both_zero;
  assign elig1     = !empty1 && ((head1 != CmdWrite) || empty0);

  always_comb begin
    sel = 1'b0;
    if (elig0 && elig1) sel = prefer_q;
    else if (elig1)     sel = 1'b1;
  end

  // WAIT_LO arbitrates directly once busy falls so strobes can be 3 cycles apart.
  assign issue_go = ((state_q == StArb) || (state_q == StWaitLo)) && !lcd_busy && (elig0 || elig1);
  assign pop0     = issue_go && !sel;
  assign pop1     = issue_go && sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StArb;
      lcd_cmd       <= NOP_CMD;
      lcd_cmd_valid <= 1'b0;
      grant_id      <= 1'b0;
      prefer_q      <= 1'b0;
      finished      <= 1'b0;
    end else begin
      unique case (state_q)
        StArb, StWaitLo: begin
          if (issue_go) begin
            lcd_cmd       <= sel ? head1 : head0;
            lcd_cmd_valid <= 1'b1;
            grant_id      <= sel;
            prefer_q      <= ~sel;
            state_q       <= StIssue;
          end else if (!lcd_busy) begin
            state_q <= StArb;
          end
        end
        StIssue: begin
          lcd_cmd       <= NOP_CMD;
          lcd_cmd_valid <= 1'b0;
          state_q       <= (lcd_cmd == CmdWrite) ? StDrain : StWaitHi;
        end
        StWaitHi: begin
          if (lcd_busy)      state_q <= StWaitLo;
          else if (wdog_hit) state_q <= StArb;
        end
        StDrain: begin
          if (lcd_done || wdog_hit) begin
            finished <= 1'b1;
            state_q  <= StFin;
          end
        end
        StFin: state_q <= StFin;
        default: begin
          lcd_cmd       <= NOP_CMD;
          lcd_cmd_valid <= 1'b0;
          state_q       <= StArb;
        end
      endcase
    end
  end

`ifdef LCD_SCHED_WDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYC + 1);

  logic [WdW-1:0] wdog_cnt_q;
  logic           wdog_run, wdog_err_q;

  // Runs only while still waiting; any state change lands on the cleared branch.
  assign wdog_run = ((state_q == StWaitHi) && !lcd_busy) || ((state_q == StDrain) && !lcd_done);
  assign wdog_hit = wdog_run && (wdog_cnt_q == WdW'(WDOG_CYC - 1));
  assign wdog_err = wdog_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= (wdog_run && !wdog_hit) ? wdog_cnt_q + WdW'(1) : '0;
      wdog_err_q <= wdog_err_q | wdog_hit;
    end
  end
`else
  logic unused_wdog_cyc;
  assign unused_wdog_cyc = ^WDOG_CYC;
  assign wdog_hit        = 1'b0;
  assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed self-checking bench for lcd_cmd_sched with a one-cycle busy controller model.
module tb_lcd_cmd_sched;

  localparam logic [3:0] Nop = 4'hF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] h0_cmd = '0, h1_cmd = '0;
  logic       h0_valid = 1'b0, h1_valid = 1'b0;
  logic       h0_ready, h1_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy, lcd_done = 1'b0;
  logic       grant_id, sched_idle, finished, wdog_err;

  logic busy_force = 1'b1;
  logic auto_en = 1'b1;
  logic busy_pulse = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   st_cyc[$];
  int   st_cmd[$];
  int   st_gnt[$];

  always #5 clk = ~clk;

  assign lcd_busy = busy_force | (auto_en & busy_pulse);

  lcd_cmd_sched #(
    .FIFO_DEPTH (4),
    .NOP_CMD    (4'hF),
    .WDOG_CYC   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .h0_cmd        (h0_cmd),
    .h0_valid      (h0_valid),
    .h0_ready      (h0_ready),
    .h1_cmd        (h1_cmd),
    .h1_valid      (h1_valid),
    .h1_ready      (h1_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .grant_id      (grant_id),
    .sched_idle    (sched_idle),
    .finished      (finished),
    .wdog_err      (wdog_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Controller answers each strobe with busy high for exactly the next cycle.
  always @(posedge clk) begin
    busy_pulse <= lcd_cmd_valid;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (lcd_cmd_valid) begin
      st_cyc.push_back(cyc);
      st_cmd.push_back(int'(lcd_cmd));
      st_gnt.push_back(int'(grant_id));
    end else begin
      check("nop_idle", int'(lcd_cmd), int'(Nop));
    end
  end

  task automatic do_reset(input logic busy_init, input logic auto_init);
    reset = 1'b0;
    h0_valid = 1'b0;
    h1_valid = 1'b0;
    lcd_done = 1'b0;
    busy_force = busy_init;
    auto_en = auto_init;
    st_cyc.delete();
    st_cmd.delete();
    st_gnt.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push(input logic host, input logic [3:0] code);
    @(negedge clk);
    if (host) begin
      h1_cmd = code;
      h1_valid = 1'b1;
    end else begin
      h0_cmd = code;
      h0_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    h0_valid = 1'b0;
    h1_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    for (int i = 0; i < budget && st_cmd.size() < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic release_busy();
    @(negedge clk);
    busy_force = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset values
    do_reset(1'b1, 1'b1);
    #1;
    check("rst_cmd", int'(lcd_cmd), int'(Nop));
    check("rst_valid", int'(lcd_cmd_valid), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_wdog", int'(wdog_err), 0);
    check("rst_idle", int'(sched_idle), 1);
    check("rst_h0_ready", int'(h0_ready), 1);
    check("rst_h1_ready", int'(h1_ready), 1);

    // Busy after reset holds off issue; then 1,5,7 go out 3 cycles apart
    push(1'b0, 4'd1);
    push(1'b0, 4'd5);
    push(1'b0, 4'd7);
    repeat (61) @(posedge clk);
    #1;
    check("s1_no_strobe_busy", st_cmd.size(), 0);
    check("s1_idle_busy", int'(sched_idle), 0);
    release_busy();
    wait_strobes(3, 30);
    check("s1_count", st_cmd.size(), 3);
    if (st_cmd.size() == 3) begin
      check("s1_cmd0", st_cmd[0], 1);
      check("s1_cmd1", st_cmd[1], 5);
      check("s1_cmd2", st_cmd[2], 7);
      check("s1_gap01", st_cyc[1] - st_cyc[0], 3);
      check("s1_gap12", st_cyc[2] - st_cyc[1], 3);
      for (int i = 0; i < 3; i++) check("s1_grant", st_gnt[i], 0);
    end

    // Round-robin between preloaded hosts
    do_reset(1'b1, 1'b1);
    push(1'b0, 4'd2);
    push(1'b0, 4'd3);
    push(1'b1, 4'd8);
    push(1'b1, 4'd9);
    release_busy();
    wait_strobes(4, 40);
    check("s2_count", st_cmd.size(), 4);
    if (st_cmd.size() == 4) begin
      check("s2_cmd0", st_cmd[0], 2);
      check("s2_cmd1", st_cmd[1], 8);
      check("s2_cmd2", st_cmd[2], 3);
      check("s2_cmd3", st_cmd[3], 9);
      check("s2_gnt0", st_gnt[0], 0);
      check("s2_gnt1", st_gnt[1], 1);
      check("s2_gnt2", st_gnt[2], 0);
      check("s2_gnt3", st_gnt[3], 1);
    end

    // Full FIFO refuses the fifth push
    do_reset(1'b1, 1'b1);
    push(1'b1, 4'd1);
    push(1'b1, 4'd2);
    push(1'b1, 4'd3);
    check("s3_ready_before_full", int'(h1_ready), 1);
    push(1'b1, 4'd4);
    check("s3_full_ready", int'(h1_ready), 0);
    check("s3_other_ready", int'(h0_ready), 1);
    push(1'b1, 4'd6);
    release_busy();
    wait_strobes(5, 40);
    check("s3_count", st_cmd.size(), 4);
    if (st_cmd.size() == 4) begin
      for (int i = 0; i < 4; i++) check("s3_cmd", st_cmd[i], i + 1);
    end

    // WRITE is held until host 1 drains, then locks pushes until done
    do_reset(1'b1, 1'b1);
    push(1'b0, 4'd0);
    push(1'b1, 4'd10);
    push(1'b1, 4'd11);
    release_busy();
    wait_strobes(3, 40);
    check("s4_count", st_cmd.size(), 3);
    if (st_cmd.size() == 3) begin
      check("s4_cmd0", st_cmd[0], 10);
      check("s4_cmd1", st_cmd[1], 11);
      check("s4_cmd2", st_cmd[2], 0);
      check("s4_gnt2", st_gnt[2], 0);
    end
    check("s4_h0_ready_lock", int'(h0_ready), 0);
    check("s4_h1_ready_lock", int'(h1_ready), 0);
    check("s4_not_finished", int'(finished), 0);
    push(1'b1, 4'd3);
    @(negedge clk);
    lcd_done = 1'b1;
    @(posedge clk);
    #1;
    lcd_done = 1'b0;
    check("s4_finished", int'(finished), 1);
    check("s4_fin_not_idle", int'(sched_idle), 0);
    check("s4_fin_ready", int'(h1_ready), 0);
    repeat (10) @(posedge clk);
    #1;
    check("s4_no_more_strobes", st_cmd.size(), 3);
    check("s4_finished_sticky", int'(finished), 1);

    // Controller never raises busy: watchdog (if built) or an unbounded wait
    do_reset(1'b0, 1'b0);
    push(1'b1, 4'd5);
    wait_strobes(1, 10);
    check("s5_count", st_cmd.size(), 1);
    check("s5_grant", int'(grant_id), 1);
    repeat (15) @(posedge clk);
    #1;
    check("s5_wdog_early", int'(wdog_err), 0);
    @(posedge clk);
    #1;
`ifdef LCD_SCHED_WDOG_EN
    check("s5_wdog_set", int'(wdog_err), 1);
    check("s5_back_to_arb", int'(sched_idle), 1);
`else
    check("s5_wdog_tied", int'(wdog_err), 0);
    check("s5_still_waiting", int'(sched_idle), 0);
`endif
    busy_force = 1'b1;
    push(1'b1, 4'd6);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("s5_rst_cmd", int'(lcd_cmd), int'(Nop));
    check("s5_rst_valid", int'(lcd_cmd_valid), 0);
    check("s5_rst_grant", int'(grant_id), 0);
    check("s5_rst_wdog", int'(wdog_err), 0);
    check("s5_rst_finished", int'(finished), 0);
    check("s5_rst_idle", int'(sched_idle), 1);
    @(negedge clk);
    reset = 1'b1;
    busy_force = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("s5_queue_lost", st_cmd.size(), 1);

    // Reset during a strobe kills it immediately
    do_reset(1'b0, 1'b1);
    push(1'b0, 4'd9);
    for (int i = 0; i < 10 && !lcd_cmd_valid; i++) @(negedge clk);
    check("s6_strobe_seen", int'(lcd_cmd_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    check("s6_rst_valid", int'(lcd_cmd_valid), 0);
    check("s6_rst_cmd", int'(lcd_cmd), int'(Nop));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler in front of the LCD image controller. It lets two independent hosts share the controller's single command port. Each host gets its own small command FIFO. Commands are granted round-robin and issued one at a time under the controller's `busy` handshake. The terminal write command (0) is held back until all other queued work has drained, and completion is reported once the controller signals `done`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per host FIFO; must be a power of 2 and at least 2.
- `NOP_CMD`, default 4'hF: code driven on `lcd_cmd` whenever no command is being issued. It must fall in the controller's default (no-effect) branch.
- `WDOG_CYC`, default 16: watchdog limit in cycles. Used only with `LCD_SCHED_WDOG_EN`.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `h0_cmd`  in  4  host 0 command code.
- `h0_valid`  in  1  host 0 push request.
- `h0_ready`  out  1  host 0 FIFO can accept.
- `h1_cmd`  in  4  host 1 command code.
- `h1_valid`  in  1  host 1 push request.
- `h1_ready`  out  1  host 1 FIFO can accept.
- `lcd_cmd`  out  4  command to the controller (registered).
- `lcd_cmd_valid`  out  1  one-cycle issue strobe (registered).
- `lcd_busy`  in  1  controller busy.
- `lcd_done`  in  1  controller finished writing output.
- `grant_id`  out  1  host that owns the last issued command.
- `sched_idle`  out  1  both FIFOs are empty and the FSM is in ARB.
- `finished`  out  1  sticky; set after the write command completes.
- `wdog_err`  out  1  sticky watchdog flag (tied 0 without the macro).

## Operation
- Reset values: `lcd_cmd`=NOP_CMD, `lcd_cmd_valid`=0, `grant_id`=0, `finished`=0, `wdog_err`=0. Both FIFOs are emptied and the round-robin pointer favours host 0.
- `hN_ready` = !full && !drain_lock. A push happens when valid and ready are both high. A full FIFO accepts nothing and there is no bypass.
- FSM states: ARB, ISSUE, WAIT_HI, WAIT_LO, DRAIN, FIN.
- ARB, candidate selection:
  - Host N is eligible when its FIFO is non-empty, AND its head is not 0 or the other FIFO is empty.
  - If both hosts are eligible, grant the host that was not granted last.
  - If both heads are 0, grant host 0.
- ARB, issue: when `lcd_busy`=0 and a host is eligible, pop its head, register it onto `lcd_cmd`, set `lcd_cmd_valid`, update `grant_id`, and go to ISSUE.
- ISSUE: lasts exactly one cycle with the strobe high. Next cycle `lcd_cmd` returns to NOP_CMD and the strobe drops.
  - Issued code ≠ 0: go to WAIT_HI.
  - Issued code = 0: go to DRAIN and set drain_lock.
- WAIT_HI: wait for `lcd_busy`=1, then go to WAIT_LO.
- WAIT_LO: wait for `lcd_busy`=0, then go to ARB.
- DRAIN: all pushes are blocked and FIFO contents are discarded. Wait for `lcd_done`=1, then go to FIN.
- FIN: `finished`=1 and the block stays here until reset. `lcd_cmd` holds NOP_CMD.
- `lcd_cmd` must never carry any non-NOP code except during the strobe cycle. The controller acts on `cmd` during READ_CMD regardless of valid, so a stray code would corrupt the image.
- Simultaneous push and pop on the same FIFO in one cycle are both performed; occupancy is unchanged.

## Timing
- Push to earliest issue: a push at edge t lands in the FIFO at t+1. ARB sees it at t+1 and the strobe is visible from t+2.
- Issue spacing: at least 3 cycles between strobes. Sequence is strobe at t, busy rises t+1, busy falls t+2, next strobe at t+3.
- While the controller loads its image (busy high after reset), ARB waits; FIFOs keep filling up to FIFO_DEPTH.
- Asynchronous reset mid-operation: all outputs take their reset values immediately, including any strobe in flight, and queued commands are lost.

## Configuration
- `LCD_SCHED_WDOG_EN`, when defined: a counter runs while the FSM is in WAIT_HI or DRAIN.
  - It clears on every state change.
  - Reaching WDOG_CYC sets `wdog_err` (sticky) and forces the FSM to ARB (from WAIT_HI) or FIN (from DRAIN).
- Without the macro: no counter is built, `wdog_err` is tied 0, and waits are unbounded.

## Structure
- `lcd_sched_pkg` holds:
  - the FSM state enum;
  - command code constants: WRITE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, MAX=5, MIN=6, AVG=7, ROT_CCW=8, ROT_CW=9, MIR_X=10, MIR_Y=11;
  - the NOP_CMD default.
- One sub-module, `lcd_cmd_fifo` (parameterised depth, 4-bit width, push/pop/full/empty/head/flush), instantiated twice.

## Test plan
- Reset, then hold `lcd_busy`=1 for 64 cycles while pushing h0 = 1,5,7 → no strobe while busy; after busy falls, strobes carry 1,5,7 spaced exactly 3 cycles apart and `grant_id`=0.
- Both hosts preloaded (h0: 2,3; h1: 8,9) → issue order 2,8,3,9 and `grant_id` sequence 0,1,0,1.
- Push 4 codes into h1 with no issues allowed, then a 5th → `h1_ready`=0 and the 5th is not stored; only 4 codes are issued.
- h0 = 0 queued while h1 holds 10,11 → 10 and 11 issue first, then 0; next cycle both readies drop; `lcd_done` pulse → `finished`=1.
- Check `lcd_cmd` on every non-strobe cycle across all scenarios → always 4'hF.
- With `LCD_SCHED_WDOG_EN`, WDOG_CYC=16, issue 5 and hold `lcd_busy`=0 → `wdog_err`=1 sixteen cycles after entering WAIT_HI and the FSM returns to ARB. Deassert `reset` mid-wait → all outputs at reset values within the same cycle.
